exu_issue_ctrl: RTL and testbench

EXU_ISSUE_CTRL -- requirements
Module: exu_issue_ctrl

---
 rtl/exu_iss_pkg.sv | 14 +
 rtl/exu_scoreboard.sv | 51 +++++
 rtl/exu_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_exu_issue_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_iss_pkg.sv
// Shared types and default sizing for the execution-unit issue controller.
package exu_iss_pkg;

  localparam int unsigned CHN_NUM_DEF = 5;
  localparam int unsigned MAX_OUT_DEF = 2;
  localparam int unsigned GPR_NUM_DEF = 32;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } iss_state_e;

endpackage

// File: rtl/exu_scoreboard.sv
// GPR pending-write scoreboard: one set port, one clear port per channel, three lookups.
module exu_scoreboard
  import exu_iss_pkg::*;
#(
  parameter int unsigned GPR_NUM  = GPR_NUM_DEF,
  parameter int unsigned CHN_NUM  = CHN_NUM_DEF,
  localparam int unsigned GPR_W   = $clog2(GPR_NUM)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     set_vld_i,
  input  logic [GPR_W-1:0]         set_idx_i,
  input  logic [CHN_NUM-1:0]       clr_vld_i,
  input  logic [CHN_NUM*GPR_W-1:0] clr_idx_i,
  input  logic [GPR_W-1:0]         rs1_idx_i,
  input  logic [GPR_W-1:0]         rs2_idx_i,
  input  logic [GPR_W-1:0]         rd_idx_i,
  output logic                     rs1_pend_o,
  output logic                     rs2_pend_o,
  output logic                     rd_pend_o
);

  logic [GPR_NUM-1:0] pend_q, pend_d;

  // Clears first so a same-cycle set to the same register wins; r0 is never pending.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned c = 0; c < CHN_NUM; c++) begin
      if (clr_vld_i[c]) begin
        pend_d[clr_idx_i[c*GPR_W +: GPR_W]] = 1'b0;
      end
    end
    if (set_vld_i) begin
      pend_d[set_idx_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign rs1_pend_o = pend_q[rs1_idx_i];
  assign rs2_pend_o = pend_q[rs2_idx_i];
  assign rd_pend_o  = pend_q[rd_idx_i];

endmodule

// File: rtl/exu_issue_ctrl.sv
// Issue controller: hazard check against the GPR scoreboard, per-channel credit limit, drain FSM.
module exu_issue_ctrl
  import exu_iss_pkg::*;
#(
  parameter int unsigned CHN_NUM = CHN_NUM_DEF,
  parameter int unsigned MAX_OUT = MAX_OUT_DEF,
  parameter int unsigned GPR_NUM = GPR_NUM_DEF,
  localparam int unsigned GPR_W  = $clog2(GPR_NUM),
  localparam int unsigned CHN_W  = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic [CHN_W-1:0]         req_chn,
  input  logic [GPR_W-1:0]         req_rs1,
  input  logic [GPR_W-1:0]         req_rs2,
  input  logic                     req_rs1_use,
  input  logic                     req_rs2_use,
  input  logic [GPR_W-1:0]         req_rd,
  input  logic                     req_rd_wr,
  input  logic                     fl_vld,
  output logic [CHN_NUM-1:0]       iss_vld,
  input  logic [CHN_NUM-1:0]       iss_rdy,
  input  logic [CHN_NUM-1:0]       cmp_vld,
  input  logic [CHN_NUM*GPR_W-1:0] cmp_rd,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     err,
  output logic [31:0]              stall_cnt
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_OUT);

  iss_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [CHN_NUM];
  logic [CNT_W-1:0]   cnt_d [CHN_NUM];
  logic               err_q, err_d;
  logic [31:0]        stall_q, stall_d;

  logic               chn_ok;
  logic [CHN_W-1:0]   chn_idx;
  logic               rs1_pend, rs2_pend, rd_pend;
  logic               hazard, can_iss, issue, all_idle;
  logic [CHN_NUM-1:0] inc_vec;

  exu_scoreboard #(
    .GPR_NUM(GPR_NUM),
    .CHN_NUM(CHN_NUM)
  ) u_scoreboard (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .set_vld_i (issue & req_rd_wr),
    .set_idx_i (req_rd),
    .clr_vld_i (cmp_vld),
    .clr_idx_i (cmp_rd),
    .rs1_idx_i (req_rs1),
    .rs2_idx_i (req_rs2),
    .rd_idx_i  (req_rd),
    .rs1_pend_o(rs1_pend),
    .rs2_pend_o(rs2_pend),
    .rd_pend_o (rd_pend)
  );

  // Out-of-range channels are steered to 0 for indexing; chn_ok masks the result.
  assign chn_ok  = 32'(req_chn) < CHN_NUM;
  assign chn_idx = chn_ok ? req_chn : '0;
  assign hazard  = (req_rs1_use & rs1_pend) | (req_rs2_use & rs2_pend) | (req_rd_wr & rd_pend);
  assign can_iss = rst_n & req_vld & ~fl_vld & ~hazard & chn_ok &
                   (cnt_q[chn_idx] < CntMax) & (state_q == StRun);

  always_comb begin
    for (int unsigned i = 0; i < CHN_NUM; i++) begin
      iss_vld[i] = can_iss & (chn_idx == CHN_W'(i));
    end
  end

  assign inc_vec = iss_vld & iss_rdy;
  assign issue   = |inc_vec;
  // Flushed and bad-channel requests are consumed without issuing.
  assign req_rdy = fl_vld | (req_vld & ~chn_ok) | issue;

  always_comb begin
    err_d    = err_q | (req_vld & ~chn_ok);
    stall_d  = stall_q;
    all_idle = 1'b1;
    for (int unsigned i = 0; i < CHN_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      all_idle = all_idle & (cnt_q[i] == '0);
      if (cmp_vld[i] && (cnt_q[i] == '0)) begin
        err_d = 1'b1;
      end
      if (inc_vec[i] && !cmp_vld[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!inc_vec[i] && cmp_vld[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    if (req_vld && !fl_vld && hazard && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end

    state_d = state_q;
    unique case (state_q)
      StRun:   if (drain_req) state_d = StDrain;
      StDrain: if (all_idle) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      err_q   <= 1'b0;
      stall_q <= '0;
      for (int unsigned i = 0; i < CHN_NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign drain_done = (state_q == StDone);
  assign err        = err_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Directed scenarios plus a randomized run against a spec-level reference model.
module tb_exu_issue_ctrl;

  localparam int CHN = 5;
  localparam int MAXO = 2;
  localparam int GW = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld, req_rdy;
  logic [2:0]  req_chn;
  logic [4:0]  req_rs1, req_rs2, req_rd;
  logic        req_rs1_use, req_rs2_use, req_rd_wr;
  logic        fl_vld;
  logic [4:0]  iss_vld, iss_rdy, cmp_vld;
  logic [24:0] cmp_rd;
  logic        drain_req, drain_done, err;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exu_issue_ctrl #(
    .CHN_NUM(CHN),
    .MAX_OUT(MAXO),
    .GPR_NUM(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_chn    (req_chn),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rs1_use(req_rs1_use),
    .req_rs2_use(req_rs2_use),
    .req_rd     (req_rd),
    .req_rd_wr  (req_rd_wr),
    .fl_vld     (fl_vld),
    .iss_vld    (iss_vld),
    .iss_rdy    (iss_rdy),
    .cmp_vld    (cmp_vld),
    .cmp_rd     (cmp_rd),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .err        (err),
    .stall_cnt  (stall_cnt)
  );

  task automatic idle();
    req_vld = 0; req_chn = 0; req_rs1 = 0; req_rs2 = 0; req_rd = 0;
    req_rs1_use = 0; req_rs2_use = 0; req_rd_wr = 0; fl_vld = 0;
    iss_rdy = '1; cmp_vld = '0; cmp_rd = '0; drain_req = 0;
  endtask

  task automatic set_req(input int chn, input int rs1, input bit u1, input int rs2,
                         input bit u2, input int rd, input bit wr);
    req_vld = 1; req_chn = 3'(chn);
    req_rs1 = 5'(rs1); req_rs1_use = u1;
    req_rs2 = 5'(rs2); req_rs2_use = u2;
    req_rd = 5'(rd); req_rd_wr = wr;
  endtask

  task automatic set_cmp(input int chn, input int rd);
    cmp_vld[chn] = 1'b1;
    cmp_rd[chn*GW +: GW] = 5'(rd);
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk); idle(); rst_n = 0; set_req(0, 1, 1, 2, 1, 3, 1); #1;
    checks++; if (iss_vld !== 5'b0) begin errors++;
      $display("FAIL reset_iss_vld: got %b expected %b", iss_vld, 5'b0); end
    @(negedge clk); #1;
    checks++; if (req_rdy !== 1'b0) begin errors++;
      $display("FAIL reset_req_rdy: got %b expected 0", req_rdy); end
    @(negedge clk); rst_n = 1; idle(); #1;
    checks++; if (err !== 1'b0) begin errors++;
      $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (stall_cnt !== 32'd0) begin errors++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (drain_done !== 1'b0) begin errors++;
      $display("FAIL reset_drain_done: got %b expected 0", drain_done); end
    @(negedge clk); idle(); set_req(1, 0, 0, 0, 0, 9, 1); #1;
    checks++; if (iss_vld !== 5'b00010) begin errors++;
      $display("FAIL reset_pre_issue: got %b expected %b", iss_vld, 5'b00010); end
    @(negedge clk); idle(); rst_n = 0;
    @(negedge clk); rst_n = 1; set_req(1, 9, 1, 0, 0, 0, 0); #1;
    checks++; if (iss_vld !== 5'b00010) begin errors++;
      $display("FAIL reset_clears_pend: got %b expected %b", iss_vld, 5'b00010); end
  endtask

  task automatic test_raw_hazard();
    do_reset();
    @(negedge clk); idle(); set_req(0, 0, 0, 0, 0, 5, 1); #1;
    checks++; if (iss_vld !== 5'b00001 || req_rdy !== 1'b1) begin errors++;
      $display("FAIL raw_first_issue: got iss=%b rdy=%b expected 00001/1", iss_vld, req_rdy); end
    @(negedge clk); idle(); set_req(0, 5, 1, 0, 0, 0, 0); #1;
    checks++; if (iss_vld !== 5'b0 || req_rdy !== 1'b0) begin errors++;
      $display("FAIL raw_stall: got iss=%b rdy=%b expected 00000/0", iss_vld, req_rdy); end
    @(negedge clk); set_cmp(0, 5); #1;
    checks++; if (req_rdy !== 1'b0) begin errors++;
      $display("FAIL raw_no_bypass: got rdy=%b expected 0", req_rdy); end
    checks++; if (stall_cnt !== 32'd1) begin errors++;
      $display("FAIL raw_stall_cnt1: got %0d expected 1", stall_cnt); end
    @(negedge clk); cmp_vld = '0; #1;
    checks++; if (iss_vld !== 5'b00001 || req_rdy !== 1'b1) begin errors++;
      $display("FAIL raw_release: got iss=%b rdy=%b expected 00001/1", iss_vld, req_rdy); end
    checks++; if (stall_cnt !== 32'd2) begin errors++;
      $display("FAIL raw_stall_cnt2: got %0d expected 2", stall_cnt); end
  endtask

  task automatic test_max_out();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle(); set_req(2, 0, 0, 0, 0, 0, 0); #1;
      checks++; if (iss_vld !== 5'b00100) begin errors++;
        $display("FAIL maxout_issue%0d: got %b expected %b", k, iss_vld, 5'b00100); end
    end
    @(negedge clk); #1;
    checks++; if (iss_vld !== 5'b0 || req_rdy !== 1'b0) begin errors++;
      $display("FAIL maxout_hold: got iss=%b rdy=%b expected 00000/0", iss_vld, req_rdy); end
    @(negedge clk); set_cmp(2, 0); #1;
    checks++; if (iss_vld !== 5'b0) begin errors++;
      $display("FAIL maxout_cmp_cycle: got %b expected 00000", iss_vld); end
    @(negedge clk); cmp_vld = '0; iss_rdy = '0; #1;
    checks++; if (iss_vld !== 5'b00100 || req_rdy !== 1'b0) begin errors++;
      $display("FAIL maxout_rdy_indep: got iss=%b rdy=%b expected 00100/0", iss_vld, req_rdy); end
    @(negedge clk); iss_rdy = '1; #1;
    checks++; if (iss_vld !== 5'b00100 || req_rdy !== 1'b1) begin errors++;
      $display("FAIL maxout_third: got iss=%b rdy=%b expected 00100/1", iss_vld, req_rdy); end
    checks++; if (err !== 1'b0) begin errors++;
      $display("FAIL maxout_err: got %b expected 0", err); end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk); idle(); set_req(1, 0, 0, 0, 0, 3, 1);
    @(negedge clk); idle(); set_req(1, 0, 0, 3, 1, 0, 0); fl_vld = 1; #1;
    checks++; if (req_rdy !== 1'b1 || iss_vld !== 5'b0) begin errors++;
      $display("FAIL flush_accept: got rdy=%b iss=%b expected 1/00000", req_rdy, iss_vld); end
    @(negedge clk); fl_vld = 0; #1;
    checks++; if (req_rdy !== 1'b0 || iss_vld !== 5'b0) begin errors++;
      $display("FAIL flush_pend_kept: got rdy=%b iss=%b expected 0/00000", req_rdy, iss_vld); end
    checks++; if (stall_cnt !== 32'd0) begin errors++;
      $display("FAIL flush_no_stall: got %0d expected 0", stall_cnt); end
    @(negedge clk); idle(); set_req(1, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (iss_vld !== 5'b00010) begin errors++;
      $display("FAIL flush_second: got %b expected 00010", iss_vld); end
    @(negedge clk); #1;
    checks++; if (iss_vld !== 5'b0) begin errors++;
      $display("FAIL flush_cnt_kept: got %b expected 00000", iss_vld); end
  endtask

  task automatic test_set_wins();
    do_reset();
    @(negedge clk); idle(); set_req(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); idle(); set_req(0, 0, 0, 0, 0, 7, 1); set_cmp(1, 7); #1;
    checks++; if (iss_vld !== 5'b00001) begin errors++;
      $display("FAIL setwin_issue: got %b expected 00001", iss_vld); end
    @(negedge clk); idle(); set_req(0, 7, 1, 0, 0, 0, 0); #1;
    checks++; if (req_rdy !== 1'b0 || iss_vld !== 5'b0) begin errors++;
      $display("FAIL setwin_pend7: got rdy=%b iss=%b expected 0/00000", req_rdy, iss_vld); end
    checks++; if (err !== 1'b0) begin errors++;
      $display("FAIL setwin_err: got %b expected 0", err); end
  endtask

  task automatic test_drain();
    do_reset();
    @(negedge clk); idle(); set_req(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); idle(); drain_req = 1;
    @(negedge clk); drain_req = 0; set_req(1, 0, 0, 0, 0, 0, 0); set_cmp(0, 0); #1;
    checks++; if (iss_vld !== 5'b0 || req_rdy !== 1'b0 || drain_done !== 1'b0) begin errors++;
      $display("FAIL drain_block: got iss=%b rdy=%b dd=%b expected 00000/0/0",
               iss_vld, req_rdy, drain_done); end
    @(negedge clk); cmp_vld = '0; #1;
    checks++; if (iss_vld !== 5'b0 || drain_done !== 1'b0) begin errors++;
      $display("FAIL drain_wait: got iss=%b dd=%b expected 00000/0", iss_vld, drain_done); end
    @(negedge clk); drain_req = 1; #1;
    checks++; if (drain_done !== 1'b1 || iss_vld !== 5'b0) begin errors++;
      $display("FAIL drain_done_pulse: got dd=%b iss=%b expected 1/00000", drain_done, iss_vld); end
    @(negedge clk); drain_req = 0; #1;
    checks++; if (drain_done !== 1'b0 || iss_vld !== 5'b00010) begin errors++;
      $display("FAIL drain_back_run: got dd=%b iss=%b expected 0/00010", drain_done, iss_vld); end
    do_reset();
    @(negedge clk); idle(); drain_req = 1;
    @(negedge clk); drain_req = 0; #1;
    checks++; if (drain_done !== 1'b0) begin errors++;
      $display("FAIL drain_idle_traverse: got %b expected 0", drain_done); end
    @(negedge clk); #1;
    checks++; if (drain_done !== 1'b1) begin errors++;
      $display("FAIL drain_idle_done: got %b expected 1", drain_done); end
    @(negedge clk); #1;
    checks++; if (drain_done !== 1'b0) begin errors++;
      $display("FAIL drain_idle_end: got %b expected 0", drain_done); end
  endtask

  task automatic test_err();
    do_reset();
    @(negedge clk); idle(); set_req(0, 0, 0, 0, 0, 0, 1); #1;
    checks++; if (iss_vld !== 5'b00001) begin errors++;
      $display("FAIL err_rd0_issue: got %b expected 00001", iss_vld); end
    @(negedge clk); idle(); set_req(0, 0, 1, 0, 0, 0, 0); #1;
    checks++; if (iss_vld !== 5'b00001) begin errors++;
      $display("FAIL err_pend0_zero: got %b expected 00001", iss_vld); end
    @(negedge clk); idle(); set_cmp(3, 4); #1;
    checks++; if (err !== 1'b0) begin errors++;
      $display("FAIL err_before: got %b expected 0", err); end
    @(negedge clk); idle(); #1;
    checks++; if (err !== 1'b1) begin errors++;
      $display("FAIL err_cnt_underflow: got %b expected 1", err); end
    repeat (3) @(negedge clk); #1;
    checks++; if (err !== 1'b1) begin errors++;
      $display("FAIL err_sticky: got %b expected 1", err); end
    do_reset();
    @(negedge clk); idle(); set_req(6, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (err !== 1'b0) begin errors++;
      $display("FAIL err_reset_clear: got %b expected 0", err); end
    checks++; if (req_rdy !== 1'b1 || iss_vld !== 5'b0) begin errors++;
      $display("FAIL err_bad_chn_drop: got rdy=%b iss=%b expected 1/00000", req_rdy, iss_vld); end
    @(negedge clk); idle(); #1;
    checks++; if (err !== 1'b1) begin errors++;
      $display("FAIL err_bad_chn: got %b expected 1", err); end
  endtask

  task automatic test_random();
    bit mpend[32];
    int mcnt[CHN];
    bit merr;
    int mstall;
    int chn, rs1, rs2, rd, crd[CHN];
    bit vld, u1, u2, wr, fl, ok, hz, can, iss, c;
    logic [4:0] rdy, exp_iss;
    bit exp_rdy;
    do_reset();
    foreach (mpend[i]) mpend[i] = 0;
    foreach (mcnt[i]) mcnt[i] = 0;
    merr = 0; mstall = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk); idle();
      vld = ($urandom_range(0, 3) != 0);
      chn = ($urandom_range(0, 49) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7); rd = $urandom_range(0, 7);
      u1 = 1'($urandom_range(0, 1)); u2 = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 9) == 0);
      rdy = 5'($urandom_range(0, 31));
      if (vld) set_req(chn, rs1, u1, rs2, u2, rd, wr);
      fl_vld = fl; iss_rdy = rdy;
      for (int i = 0; i < CHN; i++) begin
        crd[i] = $urandom_range(0, 7);
        if (mcnt[i] > 0 && $urandom_range(0, 2) == 0) set_cmp(i, crd[i]);
      end
      ok = (chn < CHN);
      hz = (u1 && mpend[rs1]) || (u2 && mpend[rs2]) || (wr && mpend[rd]);
      can = vld && !fl && !hz && ok && (mcnt[ok ? chn : 0] < MAXO);
      exp_iss = can ? 5'(1 << chn) : 5'b0;
      iss = can && rdy[chn];
      exp_rdy = fl || (vld && !ok) || iss;
      #1;
      checks++; if (iss_vld !== exp_iss) begin errors++;
        $display("FAIL rand_iss_vld[%0d]: got %b expected %b", n, iss_vld, exp_iss); end
      checks++; if (req_rdy !== exp_rdy) begin errors++;
        $display("FAIL rand_req_rdy[%0d]: got %b expected %b", n, req_rdy, exp_rdy); end
      checks++; if (err !== merr) begin errors++;
        $display("FAIL rand_err[%0d]: got %b expected %b", n, err, merr); end
      checks++; if (stall_cnt !== 32'(mstall)) begin errors++;
        $display("FAIL rand_stall[%0d]: got %0d expected %0d", n, stall_cnt, mstall); end
      for (int i = 0; i < CHN; i++) begin
        c = cmp_vld[i];
        if (c) mpend[crd[i]] = 0;
        if (c && mcnt[i] == 0) merr = 1;
        if (iss && chn == i && !c) mcnt[i]++;
        else if (!(iss && chn == i) && c && mcnt[i] > 0) mcnt[i]--;
      end
      if (iss && wr && rd != 0) mpend[rd] = 1;
      if (vld && !ok) merr = 1;
      if (vld && !fl && hz) mstall++;
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_raw_hazard();
    test_max_out();
    test_flush();
    test_set_wins();
    test_drain();
    test_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
